// File: rtl/jimmy_io_pkg.sv
// Shared types and constants for the jimmy CPU output-port peripherals.
// OUT_PORT_UART_PARITY_EN adds the PARITY state to the UART state encoding.
package jimmy_io_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned STROBE_W       = 4;

`ifdef OUT_PORT_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers for full/empty and a registered count.
// Read data is combinational from the head slot; nothing falls through on the push cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  // A push into a full FIFO is accepted only when a pop frees the head slot this cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_uart.sv
// Captures bytes written to one jimmy CPU output port and sends them as UART frames.
// Define OUT_PORT_UART_PARITY_EN to append an even-parity bit (8E1 instead of 8N1).
module out_port_uart
  import jimmy_io_pkg::*;
#(
  parameter int unsigned PORT_SEL     = 2,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [UART_DATA_BITS-1:0]     out_port,
  input  logic [STROBE_W-1:0]           out_strobe,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned SEL_W  = $clog2(STROBE_W);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [SEL_W-1:0] SEL = SEL_W'(PORT_SEL);

  logic                      stb_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      push_c;
  logic                      pop_c;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      unused_strobes;

  uart_state_t               state, state_d;
  logic [BAUD_W-1:0]         baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]          bit_cnt, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_d;
  logic                      tx_busy_d;
  logic                      baud_last;
  logic                      bit_last;
`ifdef OUT_PORT_UART_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  assign unused_strobes = ^out_strobe;

  // One push per strobe pulse, on its falling edge, using the last byte seen while high.
  assign push_c = stb_q && !out_strobe[SEL];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      stb_q <= out_strobe[SEL];
      if (out_strobe[SEL]) data_q <= out_port;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (data_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky until reset: a capture was lost because nothing could be popped to make room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else if (push_c && fifo_full && !pop_c) overflow <= 1'b1;
  end

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_cnt == BIT_W'(UART_DATA_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef OUT_PORT_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
      tx_busy  <= tx_busy_d;
`ifdef OUT_PORT_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx is the registered line level of the current state, so it trails the state by a cycle.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_q;
    tx_busy_d  = tx_busy;
    tx_d       = 1'b1;
    pop_c      = 1'b0;
`ifdef OUT_PORT_UART_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          shift_d    = fifo_dout;
          tx_busy_d  = 1'b1;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
`ifdef OUT_PORT_UART_PARITY_EN
          parity_d   = ^fifo_dout;
`endif
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_last) begin
`ifdef OUT_PORT_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
`ifdef OUT_PORT_UART_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_cnt_d = '0;
          tx_busy_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_out_port_uart.sv
// Directed bench for out_port_uart: expected bytes are queued at stimulus time and
// checked by a cycle-accurate UART receiver that also verifies every bit width.
module tb_out_port_uart;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef OUT_PORT_UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port;
  logic [3:0] out_strobe;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         rx_en     = 1'b1;
  bit         rx_active = 1'b0;

  out_port_uart #(
    .PORT_SEL     (2),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge where the strobe was dropped.
  task automatic pulse(input logic [3:0] stb, input logic [7:0] d, input int hi);
    out_port   = d;
    out_strobe = stb;
    repeat (hi) @(negedge clk);
    out_strobe = 4'b0000;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rx_active && tx_busy === 1'b0 && tx === 1'b1) break;
    end
    n_assert++;
    assert (i < budget)
    else begin
      n_fail++;
      $error("FAIL wait_idle: observed timeout with %0d frames pending, required idle within %0d cycles",
             exp_q.size(), budget);
    end
  endtask

  // Receiver: samples every cycle of a frame, so bit widths and frame length are exact.
  initial begin : rx
    logic        prev;
    logic [10:0] fr;
    bit          ok;
    logic [7:0]  e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_en && reset === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
        rx_active = 1'b1;
        ok = 1'b1;
        fr = '0;
        for (int b = 0; b < NBITS; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) fr[b] = tx;
            else if (tx !== fr[b]) ok = 1'b0;
          end
        end
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL rx_unexpected: observed frame %0h, required no frame", fr);
        end else begin
          e = exp_q.pop_front();
          chk("rx_bit_width", 32'(ok), 32'd1);
          chk("rx_start", 32'(fr[0]), 32'd0);
          chk("rx_data", 32'(fr[8:1]), 32'(e));
`ifdef OUT_PORT_UART_PARITY_EN
          chk("rx_parity", 32'(fr[9]), 32'(^e));
`endif
          chk("rx_stop", 32'(fr[NBITS-1]), 32'd1);
        end
        rx_active = 1'b0;
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: observed no end of test, required finish within 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lows;
    reset      = 1'b0;
    out_port   = 8'h00;
    out_strobe = 4'b0000;

    // Reset and idle
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(tx_busy), 32'd0);
    chk("idle_count", 32'(fifo_count), 32'd0);

    // Single byte, strobe held two cycles; tx falls three cycles after the strobe falls
    exp_q.push_back(8'h21);
    pulse(4'b0100, 8'h21, 2);
    @(negedge clk);
    chk("single_count", 32'(fifo_count), 32'd1);
    chk("single_tx_hold1", 32'(tx), 32'd1);
    @(negedge clk);
    chk("single_busy", 32'(tx_busy), 32'd1);
    chk("single_tx_hold2", 32'(tx), 32'd1);
    @(negedge clk);
    chk("single_latency", 32'(tx), 32'd0);
    wait_idle(200);

    // Strobe on a different port is ignored
    pulse(4'b0010, 8'hFF, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrong_port_count", 32'(fifo_count), 32'd0);
      chk("wrong_port_tx", 32'(tx), 32'd1);
    end

    // Burst of six: byte 1 goes straight to the shifter, 2..5 fill the FIFO, 6 is dropped
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) begin
      pulse(4'b0100, 8'(i), 1);
      @(negedge clk);
    end
    chk("burst_count_full", 32'(fifo_count), 32'd4);
    chk("burst_overflow", 32'(overflow), 32'd1);
    wait_idle(1000);
    chk("burst_overflow_sticky", 32'(overflow), 32'd1);
    chk("burst_count_drained", 32'(fifo_count), 32'd0);

    // Parity patterns (plain data in the default build)
    exp_q.push_back(8'h07);
    pulse(4'b0100, 8'h07, 1);
    exp_q.push_back(8'h03);
    @(negedge clk);
    pulse(4'b0100, 8'h03, 1);
    wait_idle(400);

    // Reset in the middle of data bit 3 of 8'hA5 aborts the frame
    rx_en = 1'b0;
    pulse(4'b0100, 8'hA5, 1);
    for (int i = 0; i < 10 && tx !== 1'b0; i++) @(negedge clk);
    chk("mid_start_seen", 32'(tx), 32'd0);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("mid_bit3", 32'(tx), 32'd0);
    chk("mid_overflow_before", 32'(overflow), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("mid_no_resend", 32'(lows), 32'd0);
    chk("mid_busy_after", 32'(tx_busy), 32'd0);
    rx_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
